// File: rtl/load_extract_unit.sv
// load_extract_unit: issues a word read, captures it into the MDR and
// produces the sign/zero-extended lw/lh/lhu/lb/lbu write-back value.
// Lanes are fixed: halfword = word[15:0], byte = word[7:0].
module load_extract_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic        invalid_type,
    output logic [31:0] load_out,
    output logic [31:0] mem_reg_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [2:0]  type_q;
    logic        inv_q;
    logic        type_ok;
    logic        accept_valid;
    logic        accept_invalid;
    logic        capture;
    logic [31:0] extracted;

    assign type_ok      = (load_type <= 3'b100);
    assign invalid_type = done & inv_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_next     = state;
        accept_valid   = 1'b0;
        accept_invalid = 1'b0;
        capture        = 1'b0;
        mem_rd         = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (type_ok) begin
                        accept_valid = 1'b1;
                        state_next   = READ;
                    end else begin
                        accept_invalid = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            READ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (count == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction of the word currently on the memory bus
    always_comb begin
        case (type_q)
            3'b001:  extracted = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  extracted = {16'h0000, mem_rdata[15:0]};
            3'b011:  extracted = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b100:  extracted = {24'h000000, mem_rdata[7:0]};
            default: extracted = mem_rdata;
        endcase
    end

    // Request latch, latency counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr     <= '0;
            type_q       <= '0;
            count        <= '0;
            inv_q        <= 1'b0;
            load_out     <= '0;
            mem_reg_data <= '0;
        end else begin
            if (accept_valid) begin
                mem_addr <= addr;
                type_q   <= load_type;
                count    <= COUNT_INIT;
                inv_q    <= 1'b0;
            end else if (accept_invalid) begin
                inv_q <= 1'b1;
            end else if (state == READ && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (capture) begin
                mem_reg_data <= mem_rdata;
                load_out     <= extracted;
            end
        end
    end

endmodule
